imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory fetch interface: receives a program image as a byte
//  stream (UART RX side), assembles big-endian 32-bit words and writes them into the
//  word-addressed instruction RAM (index = fetch Address[9:2]).
//  Holds the CPU while a load is in progress. Reports done/error status to the system.
// PARAMETERS
//  ADDR_W   8       instruction RAM word-address width; capacity 2**ADDR_W words
//  TIMEOUT  100000  max idle cycles between accepted bytes while loading; >=2
// PORTS
//  clk         in   1       system clock
//  reset       in   1       asynchronous, active-high reset
//  start       in   1       pulse: begin a load (honoured only in IDLE/DONE/ERR)
//  rx_valid    in   1       byte available
//  rx_data     in   8       byte value
//  rx_ready    out  1       loader accepts byte; transfer when rx_valid & rx_ready
//  imem_we     out  1       one-cycle instruction RAM write strobe
//  imem_waddr  out  ADDR_W  word index written
//  imem_wdata  out  32      instruction word written
//  cpu_hold    out  1       1 = CPU held in reset/stall
//  load_done   out  1       level: last load completed cleanly
//  load_err    out  2       00 none, 01 bad length, 10 timeout, 11 checksum
// BEHAVIOUR
//  Reset: state IDLE; rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_hold=0,
//   load_done=0, load_err=00; counters, assembler and checksum cleared. Reset mid-load aborts
//   with no further writes; words already written stay in RAM.
//  Frame: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes, MSB first.
//  FSM: IDLE -start-> LEN_HI -byte-> LEN_LO -byte-> DATA (if 1<=N<=2**ADDR_W) else ERR(01).
//   DATA: 4th byte of word N -> DONE (or CSUM when macro enabled). DONE/ERR -start-> LEN_HI.
//  start clears load_done/load_err and is ignored in LEN_HI/LEN_LO/DATA/CSUM.
//  rx_ready=1 exactly in LEN_HI, LEN_LO, DATA, CSUM; 0 elsewhere (incl. the ERR/DONE cycle).
//  cpu_hold=1 in LEN_HI..CSUM and ERR; 0 in IDLE and DONE. load_done=1 only in DONE.
//  Word write: on acceptance of byte 3 of word k, next cycle imem_we=1 for one cycle with
//   imem_waddr=k, imem_wdata={b0,b1,b2,b3}. Latency 1 cycle; k counts 0..N-1, no wrap.
//   imem_waddr/imem_wdata hold their last value when imem_we=0.
//  Final write strobe and entry to DONE occur on the same cycle; cpu_hold falls on that cycle.
//  Timeout: idle counter cleared on each accepted byte and on leaving IDLE/DONE/ERR. It
//   counts in LEN_HI..CSUM; reaching TIMEOUT-1 with no transfer -> ERR(10). A byte accepted
//   on that same cycle wins (no error).
//  N counts whole words; extra bytes after the frame are not accepted (rx_ready=0).
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: after the last data byte, FSM enters CSUM and accepts one
//   byte. If it equals the XOR of all 4*N data bytes -> DONE, else ERR(11). CSUM is subject to
//   the timeout. RAM writes are not rolled back.
//  Undefined: no CSUM state; the last data byte goes straight to DONE; code 11 never occurs.
// STRUCTURE
//  Package imem_loader_pkg: state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR),
//   error-code constants ERR_NONE/ERR_LEN/ERR_TIMEOUT/ERR_CSUM, default ADDR_W, TIMEOUT.
//  Sub-module imem_word_assembler: byte-lane counter + 32-bit shift register; emits word_valid
//   and word; cleared on frame start. FSM, timeout and checksum live in imem_loader.
// TESTING (TIMEOUT=16 on bench)
//  start; bytes 00 02 08 00 00 03 08 00 00 28 -> we@addr0=08000003, we@addr1=08000028, DONE.
//  Length 00 00 -> load_err=01, no imem_we, cpu_hold=1 until next start.
//  Length 01 01 with ADDR_W=8 (N=257) -> load_err=01; N=256 accepted, last waddr=FF.
//  Stall rx_valid 16 cycles after 2 data bytes -> load_err=10, no write, rx_ready=0.
//  Checksum macro on, N=1 word 20040003, csum 27 -> DONE; csum 00 -> err=11, word written.
//  Assert reset mid-DATA -> all outputs reset values next cycle; start pulse during DATA ignored.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader: FSM states,
// load_err codes and default parameter values.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_CSUM    = 2'b11;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_TIMEOUT = 100000;

  function automatic logic is_loading(input state_t s);
    return s inside {LEN_HI, LEN_LO, DATA, CSUM};
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words; o_word_valid pulses for
// one cycle after the fourth byte of each word, o_word holds between pulses.
module imem_word_assembler (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_lane_last,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_lane;
  logic [23:0] r_shift;
  logic        r_valid;
  logic [31:0] r_word;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lane  <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_word  <= '0;
    end else begin
      r_valid <= 1'b0;
      if (i_clear) begin
        r_lane  <= '0;
        r_shift <= '0;
      end else if (i_byte_valid) begin
        r_lane  <= r_lane + 2'd1;
        r_shift <= {r_shift[15:0], i_byte};
        if (r_lane == 2'd3) begin
          r_valid <= 1'b1;
          r_word  <= {r_shift, i_byte};
        end
      end
    end
  end

  assign o_lane_last  = (r_lane == 2'd3);
  assign o_word_valid = r_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte-stream program image into instruction RAM and
// holds the CPU meanwhile. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [1:0]        load_err
);

  // Wide enough for the 16-bit word count and for 2**ADDR_W itself.
  localparam int CW = (ADDR_W >= 16) ? ADDR_W + 1 : 17;
  localparam int IW = $clog2(TIMEOUT);

  state_t            r_state, w_next;
  logic [1:0]        r_err, w_err_next;
  logic [IW-1:0]     r_idle;
  logic [7:0]        r_len_hi;
  logic [CW-1:0]     r_len, r_wcnt, w_len;
  logic [ADDR_W-1:0] r_waddr;
  logic              w_active, w_accept, w_start_ok, w_timeout;
  logic              w_len_ok, w_last_word, w_lane_last, w_data_byte, w_word_end;
  logic              w_word_valid;
  logic [31:0]       w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  assign w_active    = is_loading(r_state);
  assign w_accept    = w_active & rx_valid;
  assign w_start_ok  = start & (r_state inside {IDLE, DONE, ERR});
  assign w_timeout   = w_active & ~rx_valid & (r_idle == IW'(TIMEOUT - 1));
  assign w_len       = CW'({r_len_hi, rx_data});
  assign w_len_ok    = (w_len != '0) && (w_len <= (CW'(1) << ADDR_W));
  assign w_last_word = (r_wcnt == r_len - CW'(1));
  assign w_data_byte = w_accept & (r_state == DATA);
  assign w_word_end  = w_data_byte & w_lane_last;

  imem_word_assembler u_asm (
    .i_clk        (clk),
    .i_rst        (reset),
    .i_clear      (w_start_ok),
    .i_byte_valid (w_data_byte),
    .i_byte       (rx_data),
    .o_lane_last  (w_lane_last),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_err   <= ERR_NONE;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_err_next = r_err;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (start) begin
          w_next     = LEN_HI;
          w_err_next = ERR_NONE;
        end
      end
      LEN_HI: if (w_accept) w_next = LEN_LO;
      LEN_LO: begin
        if (w_accept) begin
          if (w_len_ok) begin
            w_next = DATA;
          end else begin
            w_next     = ERR;
            w_err_next = ERR_LEN;
          end
        end
      end
      DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (w_word_end && w_last_word) w_next = CSUM;
`else
        if (w_word_end && w_last_word) w_next = DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (w_accept) begin
          if (rx_data == r_csum) begin
            w_next = DONE;
          end else begin
            w_next     = ERR;
            w_err_next = ERR_CSUM;
          end
        end
      end
`endif
      default: w_next = r_state;
    endcase
    // w_timeout already excludes a transfer on the same cycle, so a late byte wins.
    if (w_timeout) begin
      w_next     = ERR;
      w_err_next = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle   <= '0;
      r_len_hi <= '0;
      r_len    <= '0;
      r_wcnt   <= '0;
      r_waddr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum   <= '0;
`endif
    end else begin
      if (!w_active || w_accept) r_idle <= '0;
      else                       r_idle <= r_idle + IW'(1);

      if (w_start_ok) begin
        r_wcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_csum <= '0;
`endif
      end

      if (w_accept && r_state == LEN_HI) r_len_hi <= rx_data;
      if (w_accept && r_state == LEN_LO) r_len    <= w_len;

      if (w_word_end) begin
        r_waddr <= r_wcnt[ADDR_W-1:0];
        r_wcnt  <= r_wcnt + CW'(1);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (w_data_byte) r_csum <= r_csum ^ rx_data;
`endif
    end
  end

  assign rx_ready   = w_active;
  assign cpu_hold   = w_active | (r_state == ERR);
  assign load_done  = (r_state == DONE);
  assign load_err   = r_err;
  assign imem_we    = w_word_valid;
  assign imem_waddr = r_waddr;
  assign imem_wdata = w_word;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-count based reference model compared every cycle,
// directed frames with literal expectations, then randomized frames.
module tb_imem_loader;

  localparam int AW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic [1:0]    load_err;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: tracks position in the frame by accepted-byte count.
  bit          m_loading, m_done, m_we;
  logic [1:0]  m_err;
  int          m_nb, m_N, m_idle;
  logic [7:0]  m_csum;
  logic [31:0] m_word, m_wdata;
  logic [7:0]  m_waddr;

  task automatic model_byte(input logic [7:0] b);
    int d;
    m_idle = 0;
    if (m_nb == 0) begin
      m_N = int'(b) * 256;
    end else if (m_nb == 1) begin
      m_N = m_N + int'(b);
      if (m_N < 1 || m_N > (1 << AW)) begin
        m_loading = 0;
        m_err     = 2'b01;
      end
    end else if (m_nb < 2 + 4 * m_N) begin
      d      = m_nb - 2;
      m_word = {m_word[23:0], b};
      m_csum = m_csum ^ b;
      if (d % 4 == 3) begin
        m_we    = 1;
        m_waddr = 8'(d / 4);
        m_wdata = m_word;
      end
`ifndef IMEM_LOADER_CHECKSUM_EN
      if (d == 4 * m_N - 1) begin
        m_loading = 0;
        m_done    = 1;
      end
`endif
    end else begin
      if (b == m_csum) m_done = 1;
      else             m_err  = 2'b11;
      m_loading = 0;
    end
    m_nb++;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_loading = 0; m_done = 0; m_we = 0; m_err = 2'b00;
      m_nb = 0; m_N = 0; m_idle = 0; m_csum = 8'h00;
      m_word = 32'h0; m_wdata = 32'h0; m_waddr = 8'h00;
    end else begin
      m_we = 0;
      if (!m_loading) begin
        if (start) begin
          m_loading = 1; m_done = 0; m_err = 2'b00;
          m_nb = 0; m_idle = 0; m_csum = 8'h00; m_word = 32'h0;
        end
      end else if (rx_valid) begin
        model_byte(rx_data);
      end else begin
        m_idle++;
        if (m_idle >= TO) begin
          m_loading = 0;
          m_err     = 2'b10;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("rx_ready",   64'(rx_ready),   64'(m_loading));
    check("cpu_hold",   64'(cpu_hold),   64'(m_loading || (m_err != 2'b00)));
    check("load_done",  64'(load_done),  64'(m_done));
    check("load_err",   64'(load_err),   64'(m_err));
    check("imem_we",    64'(imem_we),    64'(m_we));
    check("imem_waddr", 64'(imem_waddr), 64'(m_waddr));
    check("imem_wdata", 64'(imem_wdata), 64'(m_wdata));
  end

  logic [39:0] wr_q[$];
  always @(negedge clk) if (imem_we === 1'b1) wr_q.push_back({imem_waddr, imem_wdata});

  task automatic drive_cycle(input logic st, input logic v, input logic [7:0] d);
    @(negedge clk);
    start    = st;
    rx_valid = v;
    rx_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) drive_cycle(1'b0, 1'b0, 8'($urandom));
    drive_cycle(1'b0, 1'b1, b);
  endtask

  task automatic pulse_start();
    drive_cycle(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i], 0);
  endtask

  function automatic int rgap();
    if ($urandom_range(0, 19) == 0) return int'($urandom_range(14, 18));
    return int'($urandom_range(0, 3));
  endfunction

  task automatic rand_frame();
    int         r, n, nd;
    logic [7:0] x, b;
    r = int'($urandom_range(0, 9));
    if (r == 0)      n = 0;
    else if (r == 1) n = int'($urandom_range(257, 300));
    else             n = int'($urandom_range(1, 6));
    nd = (n > 256) ? 8 : 4 * n;
    x  = 8'h00;
    pulse_start();
    send(8'(n >> 8), rgap());
    send(8'(n), rgap());
    for (int i = 0; i < nd; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      send(b, rgap());
      if ($urandom_range(0, 19) == 0) pulse_start();
    end
    if ($urandom_range(0, 2) == 0) send(x ^ 8'($urandom_range(1, 255)), rgap());
    else                           send(x, rgap());
    if ($urandom_range(0, 1) == 0) send(8'($urandom), 0);
    idle(TO + 4);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset imem_wdata", 64'(imem_wdata), 64'h0);
    check("reset cpu_hold",   64'(cpu_hold),   64'h0);
    #2 reset = 1'b0;

    // Two-word frame.
    wr_q.delete();
    pulse_start();
    send_list('{8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h08, 8'h00, 8'h00, 8'h28});
    idle(3);
    check("t1 write count", 64'(wr_q.size()), 64'd2);
    if (wr_q.size() >= 2) begin
      check("t1 write0", 64'(wr_q[0]), 64'h00_08000003);
      check("t1 write1", 64'(wr_q[1]), 64'h01_08000028);
    end
    check("t1 load_done", 64'(load_done), 64'd1);
    check("t1 model wdata", 64'(m_wdata), 64'h08000028);

    // Zero length.
    wr_q.delete();
    pulse_start();
    send_list('{8'h00, 8'h00});
    idle(4);
    check("t2 load_err", 64'(load_err), 64'd1);
    check("t2 cpu_hold", 64'(cpu_hold), 64'd1);
    check("t2 no write", 64'(wr_q.size()), 64'd0);
    check("t2 model err", 64'(m_err), 64'd1);

    // N=257 rejected, N=256 fills the RAM.
    pulse_start();
    send_list('{8'h01, 8'h01});
    idle(2);
    check("t3 N257 load_err", 64'(load_err), 64'd1);
    wr_q.delete();
    pulse_start();
    send_list('{8'h01, 8'h00});
    for (int i = 0; i < 1024; i++) send(8'($urandom), 0);
    idle(2);
    check("t3 N256 writes", 64'(wr_q.size()), 64'd256);
    if (wr_q.size() > 0) check("t3 last waddr", 64'(wr_q[$][39:32]), 64'hFF);
    check("t3 load_done", 64'(load_done), 64'd1);

    // Stall after two data bytes.
    wr_q.delete();
    pulse_start();
    send_list('{8'h00, 8'h01, 8'hAA, 8'hBB});
    idle(TO + 4);
    check("t4 load_err", 64'(load_err), 64'd2);
    check("t4 rx_ready", 64'(rx_ready), 64'd0);
    check("t4 no write", 64'(wr_q.size()), 64'd0);

    // Checksum byte (ignored as an extra byte when the feature is off).
    wr_q.delete();
    pulse_start();
    send_list('{8'h00, 8'h01, 8'h20, 8'h04, 8'h00, 8'h03, 8'h27});
    idle(2);
    check("t5 load_done", 64'(load_done), 64'd1);
    check("t5 write", 64'(wr_q.size()), 64'd1);
    if (wr_q.size() >= 1) check("t5 word", 64'(wr_q[0]), 64'h00_20040003);
`ifdef IMEM_LOADER_CHECKSUM_EN
    wr_q.delete();
    pulse_start();
    send_list('{8'h00, 8'h01, 8'h20, 8'h04, 8'h00, 8'h03, 8'h00});
    idle(2);
    check("t5 bad csum err", 64'(load_err), 64'd3);
    check("t5 bad csum written", 64'(wr_q.size()), 64'd1);
`endif

    // Start ignored mid-DATA, then reset mid-DATA.
    pulse_start();
    send(8'h00, 0); send(8'h04, 0);
    for (int i = 0; i < 9; i++) send(8'($urandom_range(1, 255)), 0);
    pulse_start();
    send(8'h11, 0); send(8'h22, 0);
    drive_cycle(1'b0, 1'b0, 8'h00);
    check("t6 still loading", 64'(rx_ready), 64'd1);
    check("t6 waddr before reset", 64'(imem_waddr), 64'd1);
    #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6 reset rx_ready", 64'(rx_ready), 64'd0);
    check("t6 reset waddr", 64'(imem_waddr), 64'd0);
    check("t6 reset wdata", 64'(imem_wdata), 64'd0);
    check("t6 reset hold", 64'(cpu_hold), 64'd0);
    #2 reset = 1'b0;
    idle(2);

    for (int f = 0; f < 40; f++) rand_frame();

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
